// File: rtl/hazard_unit_md_if.sv
// ID-stage hazard bundle: decoder/pipeline-stage facts in, stall/flush/forward/MULT-DIV control out.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_md_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2
);
  localparam int SW = $clog2(FWD_STAGES + 1);

  logic [REG_AW-1:0]            id_rs;
  logic [REG_AW-1:0]            id_rt;
  logic                         id_use_rs;
  logic                         id_use_rt;
  logic                         id_md;
  logic                         id_hilo_rd;
  logic                         id_redirect;
  logic [FWD_STAGES-1:0]        st_wreg;
  logic [FWD_STAGES-1:0]        st_m2reg;
  logic [FWD_STAGES*REG_AW-1:0] st_rn;

  logic                         stall;
  logic                         bubble;
  logic                         flush_ifid;
  logic [SW-1:0]                fwda;
  logic [SW-1:0]                fwdb;
  logic                         fwda_mem;
  logic                         fwdb_mem;
  logic                         md_go;
  logic                         md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]                  perf_lu;
  logic [31:0]                  perf_md;
  logic [31:0]                  perf_flush;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_hilo_rd, id_redirect,
    output st_wreg, st_m2reg, st_rn,
`ifdef HAZARD_PERF_EN
    input  perf_lu, perf_md, perf_flush,
`endif
    input  stall, bubble, flush_ifid, fwda, fwdb, fwda_mem, fwdb_mem, md_go, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_hilo_rd, id_redirect,
    input  st_wreg, st_m2reg, st_rn,
`ifdef HAZARD_PERF_EN
    output perf_lu, perf_md, perf_flush,
`endif
    output stall, bubble, flush_ifid, fwda, fwdb, fwda_mem, fwdb_mem, md_go, md_busy
  );
endinterface

// File: rtl/hazard_unit_md.sv
// Hazard/forwarding control beside the ID decoder: 0-cycle forward/stall/flush, MULT/DIV busy FSM
// (result readable MD_LAT+1 cycles after md_go); stalls hold until cleared. HAZARD_PERF_EN adds perf counters.
module hazard_unit_md #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int MD_LAT     = 8
) (
  input logic             clk,
  input logic             reset,
  hazard_unit_md_if.slave hz
);
  localparam int SW = $clog2(FWD_STAGES + 1);
  localparam int CW = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;

  logic [SW-1:0]     w_fwda;
  logic [SW-1:0]     w_fwdb;
  logic              w_fwda_mem;
  logic              w_fwdb_mem;
  logic [REG_AW-1:0] w_rn0;
  logic              w_lu;
  logic              w_md_haz;
  logic              w_stall;
  logic              w_flush;
  logic              w_md_go;

  // Scan from the oldest stage down so the youngest (lowest index) match overwrites.
  always_comb begin
    w_fwda     = '0;
    w_fwdb     = '0;
    w_fwda_mem = 1'b0;
    w_fwdb_mem = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hz.st_wreg[k] && (hz.st_rn[k*REG_AW +: REG_AW] != '0)) begin
        if (hz.st_rn[k*REG_AW +: REG_AW] == hz.id_rs) begin
          w_fwda     = SW'(k + 1);
          w_fwda_mem = hz.st_m2reg[k];
        end
        if (hz.st_rn[k*REG_AW +: REG_AW] == hz.id_rt) begin
          w_fwdb     = SW'(k + 1);
          w_fwdb_mem = hz.st_m2reg[k];
        end
      end
    end
  end

  assign w_rn0    = hz.st_rn[REG_AW-1:0];
  assign w_lu     = hz.st_wreg[0] & hz.st_m2reg[0] & (w_rn0 != '0) &
                    ((hz.id_use_rs & (w_rn0 == hz.id_rs)) |
                     (hz.id_use_rt & (w_rn0 == hz.id_rt)));
  assign w_md_haz = (hz.id_md | hz.id_hilo_rd) & (r_state != MD_IDLE);
  assign w_stall  = w_lu | w_md_haz;
  // A stalled branch must not flush; it is re-resolved once the stall drops.
  assign w_flush  = hz.id_redirect & ~w_stall;
  assign w_md_go  = hz.id_md & ~w_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (w_md_go) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt > CW'(1)) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_state_nxt = MD_DONE;
        end
      end
      MD_DONE: begin
        w_state_nxt = MD_IDLE;
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign hz.stall      = w_stall;
  assign hz.bubble     = w_stall;
  assign hz.flush_ifid = w_flush;
  assign hz.fwda       = w_fwda;
  assign hz.fwdb       = w_fwdb;
  assign hz.fwda_mem   = w_fwda_mem;
  assign hz.fwdb_mem   = w_fwdb_mem;
  assign hz.md_go      = w_md_go;
  assign hz.md_busy    = (r_state != MD_IDLE);

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_md;
  logic [31:0] r_perf_flush;

  // Saturating event counters; md is counted only when not already a load-use stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_lu    <= '0;
      r_perf_md    <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_lu && (r_perf_lu != '1)) begin
        r_perf_lu <= r_perf_lu + 32'd1;
      end
      if (w_md_haz && !w_lu && (r_perf_md != '1)) begin
        r_perf_md <= r_perf_md + 32'd1;
      end
      if (w_flush && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign hz.perf_lu    = r_perf_lu;
  assign hz.perf_md    = r_perf_md;
  assign hz.perf_flush = r_perf_flush;
`endif
endmodule

// File: tb/tb_hazard_unit_md.sv
// Directed-vector bench for hazard_unit_md: forwarding, load-use, $0, redirect, MULT/DIV busy and reset.
module tb_hazard_unit_md;
  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 2;
  localparam int MD_LAT     = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  hazard_unit_md_if #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) hz ();

  hazard_unit_md #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .MD_LAT    (MD_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.id_rs       = '0;
    hz.id_rt       = '0;
    hz.id_use_rs   = 1'b0;
    hz.id_use_rt   = 1'b0;
    hz.id_md       = 1'b0;
    hz.id_hilo_rd  = 1'b0;
    hz.id_redirect = 1'b0;
    hz.st_wreg     = '0;
    hz.st_m2reg    = '0;
    hz.st_rn       = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
    chk("rst_md_go", 32'(hz.md_go), 32'd0);
    chk("rst_stall", 32'(hz.stall), 32'd0);
    chk("rst_flush", 32'(hz.flush_ifid), 32'd0);
    chk("rst_fwda", 32'(hz.fwda), 32'd0);
    reset = 1'b0;

    // EX and MEM both write r5: EX wins
    hz.st_wreg = 2'b11; hz.st_rn = {5'd5, 5'd5};
    hz.id_rs = 5'd5; hz.id_use_rs = 1'b1; hz.id_rt = 5'd9; hz.id_use_rt = 1'b1;
    #1;
    chk("fwd_ex_fwda", 32'(hz.fwda), 32'd1);
    chk("fwd_ex_fwda_mem", 32'(hz.fwda_mem), 32'd0);
    chk("fwd_ex_fwdb", 32'(hz.fwdb), 32'd0);
    chk("fwd_ex_stall", 32'(hz.stall), 32'd0);

    // Only MEM holds r5, as a load result
    tick();
    hz.st_wreg = 2'b10; hz.st_m2reg = 2'b10; hz.st_rn = {5'd5, 5'd3};
    #1;
    chk("fwd_mem_fwda", 32'(hz.fwda), 32'd2);
    chk("fwd_mem_fwda_mem", 32'(hz.fwda_mem), 32'd1);
    chk("fwd_mem_stall", 32'(hz.stall), 32'd0);

    // Load to r7 in EX, consumer reads rt=r7
    tick();
    clear_in();
    hz.st_wreg = 2'b01; hz.st_m2reg = 2'b01; hz.st_rn = {5'd0, 5'd7};
    hz.id_rt = 5'd7; hz.id_use_rt = 1'b1;
    #1;
    chk("lu_stall", 32'(hz.stall), 32'd1);
    chk("lu_bubble", 32'(hz.bubble), 32'd1);
    chk("lu_md_go", 32'(hz.md_go), 32'd0);

    tick();
    hz.st_wreg = 2'b10; hz.st_m2reg = 2'b10; hz.st_rn = {5'd7, 5'd0};
    #1;
    chk("lu_after_fwdb", 32'(hz.fwdb), 32'd2);
    chk("lu_after_fwdb_mem", 32'(hz.fwdb_mem), 32'd1);
    chk("lu_after_stall", 32'(hz.stall), 32'd0);
    chk("lu_after_bubble", 32'(hz.bubble), 32'd0);

    // Same load, but ID does not read rt: no stall, forwarding select unaffected
    tick();
    hz.st_wreg = 2'b01; hz.st_m2reg = 2'b01; hz.st_rn = {5'd0, 5'd7};
    hz.id_use_rt = 1'b0; hz.id_use_rs = 1'b0;
    #1;
    chk("lu_nouse_stall", 32'(hz.stall), 32'd0);
    chk("lu_nouse_fwdb", 32'(hz.fwdb), 32'd1);

    // Register $0 never forwarded nor load-use stalled
    tick();
    clear_in();
    hz.st_wreg = 2'b11; hz.st_m2reg = 2'b11; hz.st_rn = '0;
    hz.id_use_rs = 1'b1; hz.id_use_rt = 1'b1;
    #1;
    chk("r0_fwda", 32'(hz.fwda), 32'd0);
    chk("r0_fwdb", 32'(hz.fwdb), 32'd0);
    chk("r0_fwda_mem", 32'(hz.fwda_mem), 32'd0);
    chk("r0_stall", 32'(hz.stall), 32'd0);

    // Redirect under load-use waits one cycle
    tick();
    clear_in();
    hz.st_wreg = 2'b01; hz.st_m2reg = 2'b01; hz.st_rn = {5'd0, 5'd4};
    hz.id_rs = 5'd4; hz.id_use_rs = 1'b1; hz.id_redirect = 1'b1;
    #1;
    chk("redir_lu_stall", 32'(hz.stall), 32'd1);
    chk("redir_lu_flush", 32'(hz.flush_ifid), 32'd0);
    tick();
    hz.st_wreg = 2'b10; hz.st_m2reg = 2'b10; hz.st_rn = {5'd4, 5'd0};
    #1;
    chk("redir_go_stall", 32'(hz.stall), 32'd0);
    chk("redir_go_flush", 32'(hz.flush_ifid), 32'd1);
    chk("redir_go_fwda", 32'(hz.fwda), 32'd2);

    // MULT together with redirect, then MFHI waits out the unit
    tick();
    clear_in();
    hz.id_md = 1'b1; hz.id_redirect = 1'b1;
    #1;
    chk("mult_md_go", 32'(hz.md_go), 32'd1);
    chk("mult_flush", 32'(hz.flush_ifid), 32'd1);
    chk("mult_md_busy", 32'(hz.md_busy), 32'd0);
    for (int i = 1; i <= MD_LAT + 1; i++) begin
      tick();
      clear_in();
      hz.id_hilo_rd = 1'b1;
      #1;
      chk("mfhi_md_busy", 32'(hz.md_busy), (i <= MD_LAT) ? 32'd1 : 32'd0);
      chk("mfhi_stall", 32'(hz.stall), (i <= MD_LAT) ? 32'd1 : 32'd0);
      chk("mfhi_md_go", 32'(hz.md_go), 32'd0);
    end

    // Reset in the middle of a MULT/DIV
    tick();
    clear_in();
    hz.id_md = 1'b1;
    #1;
    chk("mult2_md_go", 32'(hz.md_go), 32'd1);
    tick();
    #1;
    chk("md_back2back_stall", 32'(hz.stall), 32'd1);
    chk("md_back2back_md_go", 32'(hz.md_go), 32'd0);
    hz.id_md = 1'b0;
    tick();
    tick();
    hz.id_hilo_rd = 1'b1;
    #1;
    chk("midrst_pre_stall", 32'(hz.stall), 32'd1);
    chk("midrst_pre_busy", 32'(hz.md_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_md_busy", 32'(hz.md_busy), 32'd0);
    chk("midrst_stall", 32'(hz.stall), 32'd0);
    chk("midrst_md_go", 32'(hz.md_go), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("midrst_perf_lu", hz.perf_lu, 32'd0);
    chk("midrst_perf_md", hz.perf_md, 32'd0);
    chk("midrst_perf_flush", hz.perf_flush, 32'd0);
`endif
    hz.id_hilo_rd = 1'b0;
    hz.id_md = 1'b1;
    #1;
    chk("postrst_md_go", 32'(hz.md_go), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
